// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the debug/loader port and the data memory.
// The arbiter takes the slave view; the environment (CPU, debug master, memory) takes the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              halt;

    logic              cpu_req;
    logic              cpu_rw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [2:0]        cpu_width;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_rw;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [2:0]        dbg_width;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_width;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  halt,
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, cpu_width,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_rw, dbg_addr, dbg_wdata, dbg_width,
        output dbg_ack, dbg_rdata,
        output mem_rw, mem_addr, mem_wdata, mem_width,
        input  mem_rdata
    );

    modport master (
        output halt,
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata, cpu_width,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_rw, dbg_addr, dbg_wdata, dbg_width,
        input  dbg_ack, dbg_rdata,
        input  mem_rw, mem_addr, mem_wdata, mem_width,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has priority, debug port gets a slot within MAX_WAIT cycles
// of CPU traffic at the cost of a single CPU stall cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// CPU_OWN  | CPU drives memory; pending debug request ages in wait_cnt
// DBG_ACC  | debug port drives memory; CPU stalled if it is requesting
// DBG_DONE | dbg_ack pulse; CPU owns memory, dbg_req ignored
module dmem_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    dmem_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        DBG_ACC  = 2'd1,
        DBG_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wait_cnt, wait_d;
    logic              dbg_ack_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              dbg_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CPU_OWN;
            wait_cnt    <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_cnt  <= wait_d;
            dbg_ack_q <= (state_q == DBG_ACC);
            if ((state_q == DBG_ACC) && !bus.dbg_rw)
                dbg_rdata_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_cnt;
        case (state_q)
            CPU_OWN: begin
                if (bus.dbg_req && (!bus.cpu_req || bus.halt || wait_cnt == WAIT_MAX)) begin
                    state_d = DBG_ACC;
                    wait_d  = '0;
                end else if (!bus.dbg_req) begin
                    // a withdrawn request loses its accumulated priority
                    wait_d = '0;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_d = wait_cnt + CW'(1);
                end
            end
            DBG_ACC:  state_d = DBG_DONE;
            DBG_DONE: state_d = CPU_OWN;
            default:  state_d = CPU_OWN;
        endcase
    end

    assign dbg_sel   = (state_q == DBG_ACC);
    assign sel_addr  = dbg_sel ? bus.dbg_addr  : bus.cpu_addr;
    assign sel_wdata = dbg_sel ? bus.dbg_wdata : bus.cpu_wdata;

    // write enable is qualified by the owner's request so an idle port never stores
    assign bus.mem_rw    = dbg_sel ? (bus.dbg_req & bus.dbg_rw) : (bus.cpu_req & bus.cpu_rw);
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.mem_width = dbg_sel ? bus.dbg_width : bus.cpu_width;

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = bus.cpu_req & dbg_sel;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-word behavioural data memory.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic [63:0] mem_q [0:63];

    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus();
    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.mem_rw === 1'b1) mem_q[bus.mem_addr[8:3]] <= bus.mem_wdata;
    assign bus.mem_rdata = mem_q[bus.mem_addr[8:3]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // drives a debug request and follows it until dbg_ack (bounded)
    task automatic dbg_issue(input logic rw, input logic [63:0] addr, input logic [63:0] wdata,
                             output int lat, output int rw_cyc, output int stall_cyc,
                             output int stall_at, output int max_wait);
        @(posedge clk); #1;
        bus.dbg_req = 1'b1; bus.dbg_rw = rw; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
        lat = -1; rw_cyc = 0; stall_cyc = 0; stall_at = -1; max_wait = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_rw === 1'b1) rw_cyc++;
            if (bus.cpu_stall === 1'b1) begin stall_cyc++; if (stall_at < 0) stall_at = i; end
            if (int'(dut.wait_cnt) > max_wait) max_wait = int'(dut.wait_cnt);
            if (bus.dbg_ack === 1'b1) begin lat = i; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic dbg_release();
        @(posedge clk); #1;
        bus.dbg_req = 1'b0;
    endtask

    task automatic cpu_write(input logic [63:0] addr, input logic [63:0] data);
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = addr; bus.cpu_wdata = data;
    endtask

    task automatic cpu_idle();
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.cpu_rw = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.halt = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 64'h40; bus.cpu_wdata = 64'h0; bus.cpu_width = 3'd3;
        bus.dbg_req = 1'b0; bus.dbg_rw = 1'b0; bus.dbg_addr = 64'h0; bus.dbg_wdata = 64'h0; bus.dbg_width = 3'd3;
        #1;
        checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dut.state_q); end
        checks++; if (dut.wait_cnt !== 3'd0) begin failures++; $display("FAIL reset_wait_cnt: got %0d expected 0", dut.wait_cnt); end
        checks++; if (bus.dbg_ack !== 1'b0) begin failures++; $display("FAIL reset_dbg_ack: got %b expected 0", bus.dbg_ack); end
        checks++; if (bus.dbg_rdata !== 64'h0) begin failures++; $display("FAIL reset_dbg_rdata: got %0h expected 0", bus.dbg_rdata); end
        checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_cpu_stall: got %b expected 0", bus.cpu_stall); end
        checks++; if (bus.mem_addr !== 64'h40) begin failures++; $display("FAIL reset_mem_addr: got %0h expected 40", bus.mem_addr); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_cpu_store();
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 64'h8; bus.cpu_wdata = 64'h7;
        @(negedge clk);
        checks++; if (bus.mem_rw !== 1'b1) begin failures++; $display("FAIL store_mem_rw: got %b expected 1", bus.mem_rw); end
        checks++; if (bus.mem_addr !== 64'h8) begin failures++; $display("FAIL store_mem_addr: got %0h expected 8", bus.mem_addr); end
        checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL store_stall: got %b expected 0", bus.cpu_stall); end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.cpu_rw = 1'b0;
        checks++; if (mem_q[1] !== 64'h7) begin failures++; $display("FAIL store_mem_data: got %0h expected 7", mem_q[1]); end
    endtask

    task automatic test_idle_write_read();
        int lat, rwc, stc, sat, mw;
        bus.cpu_req = 1'b0;
        dbg_issue(1'b1, 64'h58, 64'h2A, lat, rwc, stc, sat, mw);
        checks++; if (lat !== 2) begin failures++; $display("FAIL idle_wr_latency: got %0d expected 2", lat); end
        checks++; if (rwc !== 1) begin failures++; $display("FAIL idle_wr_mem_rw_cycles: got %0d expected 1", rwc); end
        checks++; if (mem_q[11] !== 64'h2A) begin failures++; $display("FAIL idle_wr_mem: got %0h expected 2a", mem_q[11]); end
        dbg_release();
        dbg_issue(1'b0, 64'h58, 64'h0, lat, rwc, stc, sat, mw);
        checks++; if (lat !== 2) begin failures++; $display("FAIL idle_rd_latency: got %0d expected 2", lat); end
        checks++; if (rwc !== 0) begin failures++; $display("FAIL idle_rd_mem_rw_cycles: got %0d expected 0", rwc); end
        checks++; if (bus.dbg_rdata !== 64'h2A) begin failures++; $display("FAIL idle_rd_data: got %0h expected 2a", bus.dbg_rdata); end
        checks++; if (stc !== 0) begin failures++; $display("FAIL idle_stall: got %0d expected 0", stc); end
        dbg_release();
    endtask

    task automatic test_wait_restart();
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 64'h100;
        bus.dbg_req = 1'b1; bus.dbg_rw = 1'b0; bus.dbg_addr = 64'h58;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (dut.wait_cnt !== 3'd2) begin failures++; $display("FAIL restart_wait_cnt_count: got %0d expected 2", dut.wait_cnt); end
        checks++; if (bus.mem_addr !== 64'h100) begin failures++; $display("FAIL restart_mem_addr: got %0h expected 100", bus.mem_addr); end
        bus.dbg_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (dut.wait_cnt !== 3'd0) begin failures++; $display("FAIL restart_wait_cnt_clear: got %0d expected 0", dut.wait_cnt); end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_cpu_traffic();
        int lat, rwc, stc, sat, mw;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 64'h100;
        dbg_issue(1'b0, 64'h58, 64'h0, lat, rwc, stc, sat, mw);
        checks++; if (lat !== 6) begin failures++; $display("FAIL traffic_latency: got %0d expected 6", lat); end
        checks++; if (sat !== 5) begin failures++; $display("FAIL traffic_stall_cycle: got %0d expected 5", sat); end
        checks++; if (stc !== 1) begin failures++; $display("FAIL traffic_stall_count: got %0d expected 1", stc); end
        checks++; if (mw !== 4) begin failures++; $display("FAIL traffic_wait_max: got %0d expected 4", mw); end
        checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL traffic_ack_stall: got %b expected 0", bus.cpu_stall); end
        checks++; if (bus.mem_addr !== 64'h100) begin failures++; $display("FAIL traffic_ack_cpu_served: got %0h expected 100", bus.mem_addr); end
        checks++; if (bus.dbg_rdata !== 64'h2A) begin failures++; $display("FAIL traffic_rdata: got %0h expected 2a", bus.dbg_rdata); end
        dbg_release();
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_halt();
        int lat, rwc, stc, sat, mw;
        bus.halt = 1'b1; bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0;
        dbg_issue(1'b0, 64'h8, 64'h0, lat, rwc, stc, sat, mw);
        checks++; if (lat !== 2) begin failures++; $display("FAIL halt_latency: got %0d expected 2", lat); end
        checks++; if (mw !== 0) begin failures++; $display("FAIL halt_wait_cnt: got %0d expected 0", mw); end
        checks++; if (sat !== 1) begin failures++; $display("FAIL halt_stall_cycle: got %0d expected 1", sat); end
        checks++; if (bus.dbg_rdata !== 64'h7) begin failures++; $display("FAIL halt_rdata: got %0h expected 7", bus.dbg_rdata); end
        dbg_release();
        bus.halt = 1'b0; bus.cpu_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat, rwc, stc, sat, mw, prev_ack;
        for (int i = 0; i < 10; i++) cpu_write(64'h58 + 64'(8 * i), 64'hC0DE_0000_0000_0000 + 64'(i * 17));
        cpu_idle();
        prev_ack = 0;
        for (int i = 0; i < 10; i++) begin
            dbg_issue(1'b0, 64'h58 + 64'(8 * i), 64'h0, lat, rwc, stc, sat, mw);
            checks++; if (bus.dbg_rdata !== 64'hC0DE_0000_0000_0000 + 64'(i * 17)) begin
                failures++; $display("FAIL b2b_rdata[%0d]: got %0h expected %0h", i, bus.dbg_rdata, 64'hC0DE_0000_0000_0000 + 64'(i * 17));
            end
            if (i > 0) begin
                checks++; if (cyc - prev_ack !== 3) begin failures++; $display("FAIL b2b_ack_spacing[%0d]: got %0d expected 3", i, cyc - prev_ack); end
            end
            prev_ack = cyc;
        end
        dbg_release();
    endtask

    task automatic test_reset_during_write();
        int acks;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b1; bus.dbg_rw = 1'b1; bus.dbg_addr = 64'h60; bus.dbg_wdata = 64'hDEAD;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 64'h200;
        #1;
        checks++; if (dut.state_q !== 2'd1) begin failures++; $display("FAIL rstacc_pre_state: got %0d expected 1", dut.state_q); end
        checks++; if (bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL rstacc_pre_stall: got %b expected 1", bus.cpu_stall); end
        rst = 1'b1;
        #1;
        checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL rstacc_state: got %0d expected 0", dut.state_q); end
        checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL rstacc_stall: got %b expected 0", bus.cpu_stall); end
        checks++; if (bus.dbg_rdata !== 64'h0) begin failures++; $display("FAIL rstacc_rdata: got %0h expected 0", bus.dbg_rdata); end
        checks++; if (bus.mem_addr !== 64'h200) begin failures++; $display("FAIL rstacc_mem_addr: got %0h expected 200", bus.mem_addr); end
        bus.dbg_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.dbg_ack === 1'b1) acks++;
            if (i == 1) rst = 1'b0;
        end
        checks++; if (acks !== 0) begin failures++; $display("FAIL rstacc_no_ack: got %0d acks expected 0", acks); end
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_store();
        test_idle_write_read();
        test_wait_restart();
        test_cpu_traffic();
        test_halt();
        test_back_to_back();
        test_reset_during_write();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
